dma_chan_regfile: RTL and testbench
===================================

# dma_chan_regfile

Parametrised register file for the 8237-style DMA controller, replacing the flat per-channel register bundle with a self-contained sequential block. It provides CPU byte-wide access to N channels of base/current address and word-count registers through a shared byte-pointer flip-flop. It holds the command, mode, request, mask and status registers. It applies per-transfer address and count updates from the timing FSM, including terminal-count detection, autoinitialize reload and automatic masking. It sits between the CPU bus decoder and the priority encoder / transfer FSM.

## Interface
- NCH, 4: channel count, 1..DW
- DW, 8: CPU data bus width
- AW, 16: address/word-count width; multiple of DW; NB = AW/DW bytes per register
- Derived: CHW = max(1, clog2(NCH)); RAW = clog2(3*NCH+8); CTL = 2*NCH
- CLK  in  1  clock, all state updates on rising edge
- RESET  in  1  asynchronous, active-low reset
- reg_wr  in  1  CPU write strobe, one cycle per byte
- reg_rd  in  1  CPU read strobe, one cycle per byte
- reg_addr  in  RAW  register select
- din  in  DW  CPU write data
- dout  out  DW  CPU read data, registered
- xfer_step  in  1  one transfer completed on channel xfer_ch
- xfer_ch  in  CHW  channel of the transfer step
- tc_pulse  out  NCH  one-cycle terminal-count pulse per channel
- curr_addr  out  NCH×AW  current address registers, packed
- curr_word  out  NCH×AW  current word-count registers, packed
- mode_q  out  NCH×6  mode registers
- cmd_q  out  DW  command register
- req_q  out  NCH  software request bits
- mask_q  out  NCH  mask bits

## Operation
- Address map:
  - 2c = channel c address: write base+current, read current.
  - 2c+1 = channel c word count: same write/read behaviour.
  - CTL+0 = write command / read status.
  - CTL+1 = request: din[CHW-1:0] selects channel, din[CHW] = value.
  - CTL+2 = single mask, same format as request.
  - CTL+4 = clear byte pointer.
  - CTL+5 = master clear.
  - CTL+6 = clear all masks.
  - CTL+7 = write all masks from din[NCH-1:0].
  - CTL+8+c = channel c mode, from din[5:0].
  - Unmapped addresses: writes ignored, reads return 0.
- Mode bits: [1:0] transfer type, [2] autoinit, [3] address decrement, [5:4] service mode. Stored only, except bits [2] and [3].
- Byte pointer (clog2(NB) bits, minimum 1):
  - Each access to a 2c or 2c+1 address uses byte lane ptr, then ptr = (ptr+1) mod NB.
  - Shared by all channels.
  - Cleared by CTL+4, master clear and reset.
- Address/word write: lane ptr of both base and current registers takes din.
- Status read returns {0.., tc_flag[NCH-1:0]}; all tc_flags clear at that edge.
- xfer_step on channel c, ignored if cmd_q[2]=1:
  - Address: curr_addr ±1 modulo 2^AW (decrement if mode[3]).
  - Word count: curr_word −1 modulo 2^AW.
  - If curr_word was 0 (wrap to all-ones): pulse tc_pulse[c], set tc_flag[c], clear req_q[c].
  - On terminal count with mode[2]=1: curr_addr/curr_word reload from base instead of updating; mask unchanged.
  - On terminal count with mode[2]=0: mask_q[c] set.
- Master clear: cmd, tc_flags, req and ptr cleared, masks set all-ones. Base, current and mode registers retained.
- Reset values:
  - Zero: all registers, dout, tc_pulse.
  - mask_q all ones.

## Timing
- Writes take effect at the edge where reg_wr is high; visible on outputs next cycle.
- dout valid the cycle after reg_rd. dout holds its last value when no read occurs.
- Read side effects (ptr advance, tc_flag clear) occur at the reg_rd edge.
- reg_wr and reg_rd high together: write performed, read ignored, dout held.
- CPU write to channel c address/word count and xfer_step on c in the same cycle: write wins, step dropped, no tc.
- Status read and tc set in the same cycle: set wins, flag remains 1.
- Single mask clear and auto-mask at tc in the same cycle: auto-mask wins.
- tc_pulse is exactly one cycle, asserted the cycle after the step edge.
- RESET asserted mid-sequence: immediate clear; ptr restarts at lane 0.

## Structure
- Shared package dma_pkg holds:
  - Mode field positions, command bit CMD_DISABLE=2.
  - Control offsets (OFF_CMD..OFF_MODE).
  - Mode struct typedef.
- One sub-module, dma_chan_counter, instantiated NCH times. It holds the base/current address and word registers and implements step, reload, tc and byte-lane write.
- Top level holds decode, pointer, shared registers and read mux.

## Test plan
- Byte write: NCH=4, AW=16, ptr clear, write 0x34 then 0x12 to addr 2 → base and curr_addr[1] = 0x1234, ptr back to 0.
- Terminal count, no autoinit: word=0x0001, mode=0x00, two steps → curr_word 0xFFFF, tc_pulse[c] one cycle, mask_q[c]=1, status read 0x0c-bit set then cleared on second read.
- Autoinit: base addr 0x1000, word 0x0002, mode[2]=1, three steps → counters reload to 0x1000/0x0002, mask unchanged.
- Decrement: mode[3]=1, addr 0x0000, one step → 0xFFFF.
- Collisions: write to word register same cycle as step → step dropped. Status read same cycle as tc → flag reads 1 next time.
- Master clear after programming → masks 0xF, cmd 0, base/mode retained; RESET low mid-step → all outputs at reset values.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA channel register file: mode field layout,
// command bits and control-register offsets above the channel registers.
package dma_pkg;

    // Mode register layout, MSB first: service mode, decrement, autoinit, type.
    typedef struct packed {
        logic [1:0] svc;
        logic       dec;
        logic       autoinit;
        logic [1:0] xtype;
    } mode_t;

    localparam int MODE_W        = $bits(mode_t);
    localparam int MODE_AUTOINIT = 2;
    localparam int MODE_DEC      = 3;

    // Command register bit that freezes all transfer-step updates.
    localparam int CMD_DISABLE = 2;

    // Offsets relative to the first control address (2*NCH).
    localparam int OFF_CMD     = 0;
    localparam int OFF_REQ     = 1;
    localparam int OFF_SMASK   = 2;
    localparam int OFF_CLRPTR  = 4;
    localparam int OFF_MCLR    = 5;
    localparam int OFF_CLRMASK = 6;
    localparam int OFF_WRMASK  = 7;
    localparam int OFF_MODE    = 8;

endpackage

// File: rtl/dma_chan_counter.sv
// One channel's base/current address and word-count registers. Handles
// byte-lane CPU writes, per-transfer stepping, terminal count and reload.
module dma_chan_counter #(
    parameter int AW = 16,
    parameter int DW = 8,
    parameter int PW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_addr,
    input  logic          wr_word,
    input  logic [PW-1:0] lane,
    input  logic [DW-1:0] din,
    input  logic          step,
    input  logic          autoinit,
    input  logic          dec,
    output logic [AW-1:0] curr_addr,
    output logic [AW-1:0] curr_word,
    output logic          tc
);

    logic [AW-1:0] base_addr_q, base_addr_d;
    logic [AW-1:0] base_word_q, base_word_d;
    logic [AW-1:0] curr_addr_q, curr_addr_d;
    logic [AW-1:0] curr_word_q, curr_word_d;

    assign curr_addr = curr_addr_q;
    assign curr_word = curr_word_q;

    // CPU byte write takes priority; a step colliding with a write is dropped.
    always_comb begin
        base_addr_d = base_addr_q;
        base_word_d = base_word_q;
        curr_addr_d = curr_addr_q;
        curr_word_d = curr_word_q;
        tc          = 1'b0;
        if (wr_addr) begin
            base_addr_d[int'(lane)*DW +: DW] = din;
            curr_addr_d[int'(lane)*DW +: DW] = din;
        end
        if (wr_word) begin
            base_word_d[int'(lane)*DW +: DW] = din;
            curr_word_d[int'(lane)*DW +: DW] = din;
        end
        if (step && !wr_addr && !wr_word) begin
            tc = (curr_word_q == '0);
            if (tc && autoinit) begin
                curr_addr_d = base_addr_q;
                curr_word_d = base_word_q;
            end else begin
                curr_addr_d = dec ? curr_addr_q - AW'(1) : curr_addr_q + AW'(1);
                curr_word_d = curr_word_q - AW'(1);
            end
        end
    end

    // Counter state; everything clears on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_addr_q <= '0;
            base_word_q <= '0;
            curr_addr_q <= '0;
            curr_word_q <= '0;
        end else begin
            base_addr_q <= base_addr_d;
            base_word_q <= base_word_d;
            curr_addr_q <= curr_addr_d;
            curr_word_q <= curr_word_d;
        end
    end

endmodule

// File: rtl/dma_chan_regfile.sv
// 8237-style DMA register file: CPU byte access through a shared byte
// pointer, command/mode/request/mask/status registers, and per-transfer
// counter updates with terminal-count handling.
module dma_chan_regfile
    import dma_pkg::*;
#(
    parameter int NCH = 4,
    parameter int DW  = 8,
    parameter int AW  = 16,
    localparam int NB  = AW / DW,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int RAW = $clog2(3 * NCH + 8),
    localparam int CTL = 2 * NCH,
    localparam int PW  = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  reg_wr,
    input  logic                  reg_rd,
    input  logic [RAW-1:0]        reg_addr,
    input  logic [DW-1:0]         din,
    output logic [DW-1:0]         dout,
    input  logic                  xfer_step,
    input  logic [CHW-1:0]        xfer_ch,
    output logic [NCH-1:0]        tc_pulse,
    output logic [NCH*AW-1:0]     curr_addr,
    output logic [NCH*AW-1:0]     curr_word,
    output logic [NCH*MODE_W-1:0] mode_q,
    output logic [DW-1:0]         cmd_q,
    output logic [NCH-1:0]        req_q,
    output logic [NCH-1:0]        mask_q
);

    logic [PW-1:0]         ptr_q, ptr_d;
    logic [NCH-1:0]        tc_flag_q, tc_flag_d;
    logic [NCH-1:0]        tc_pulse_q, tc_pulse_d;
    logic [DW-1:0]         dout_q, dout_d;
    logic [DW-1:0]         cmd_d;
    logic [NCH-1:0]        req_d, mask_d;
    logic [NCH*MODE_W-1:0] mode_d;

    logic [NCH-1:0] wr_addr_c, wr_word_c, step_c, autoinit_c, dec_c, tc_c;
    logic [31:0]    addr_i, ch_idx, sel, rd_base;
    logic [DW-1:0]  rd_data;
    logic           chan_hit, rd_en, chan_acc;
    logic           wr_cmd, wr_req, wr_smask, wr_clrptr, wr_mclr, wr_clrmask, wr_wrmask, rd_stat;

    assign dout     = dout_q;
    assign tc_pulse = tc_pulse_q;

    // A simultaneous write suppresses the read entirely.
    assign addr_i     = 32'(reg_addr);
    assign ch_idx     = addr_i >> 1;
    assign chan_hit   = addr_i < 32'(CTL);
    assign rd_en      = reg_rd & ~reg_wr;
    assign chan_acc   = chan_hit & (reg_wr | rd_en);
    assign sel        = 32'(din[CHW-1:0]);
    assign rd_base    = ch_idx * 32'(AW) + 32'(ptr_q) * 32'(DW);
    assign wr_cmd     = reg_wr && (addr_i == 32'(CTL + OFF_CMD));
    assign wr_req     = reg_wr && (addr_i == 32'(CTL + OFF_REQ));
    assign wr_smask   = reg_wr && (addr_i == 32'(CTL + OFF_SMASK));
    assign wr_clrptr  = reg_wr && (addr_i == 32'(CTL + OFF_CLRPTR));
    assign wr_mclr    = reg_wr && (addr_i == 32'(CTL + OFF_MCLR));
    assign wr_clrmask = reg_wr && (addr_i == 32'(CTL + OFF_CLRMASK));
    assign wr_wrmask  = reg_wr && (addr_i == 32'(CTL + OFF_WRMASK));
    assign rd_stat    = rd_en && (addr_i == 32'(CTL + OFF_CMD));

    // Per-channel write strobes, step gating and mode bits for the counters.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            wr_addr_c[c]  = reg_wr & chan_hit & (ch_idx == 32'(c)) & ~addr_i[0];
            wr_word_c[c]  = reg_wr & chan_hit & (ch_idx == 32'(c)) & addr_i[0];
            step_c[c]     = xfer_step & ~cmd_q[CMD_DISABLE] & (32'(xfer_ch) == 32'(c));
            autoinit_c[c] = mode_q[c*MODE_W + MODE_AUTOINIT];
            dec_c[c]      = mode_q[c*MODE_W + MODE_DEC];
        end
    end

    dma_chan_counter #(.AW(AW), .DW(DW), .PW(PW)) u_cnt [NCH-1:0] (
        .clk       (CLK),
        .rst_n     (RESET),
        .wr_addr   (wr_addr_c),
        .wr_word   (wr_word_c),
        .lane      (ptr_q),
        .din       (din),
        .step      (step_c),
        .autoinit  (autoinit_c),
        .dec       (dec_c),
        .curr_addr (curr_addr),
        .curr_word (curr_word),
        .tc        (tc_c)
    );

    // Byte pointer advances on every channel-register access, wraps at NB.
    always_comb begin
        ptr_d = ptr_q;
        if (chan_acc)
            ptr_d = (32'(ptr_q) == 32'(NB - 1)) ? '0 : ptr_q + PW'(1);
        if (wr_clrptr || wr_mclr)
            ptr_d = '0;
    end

    // Read mux: current registers by lane, status, everything else zero.
    always_comb begin
        rd_data = '0;
        if (chan_hit)
            rd_data = addr_i[0] ? curr_word[rd_base +: DW] : curr_addr[rd_base +: DW];
        else if (addr_i == 32'(CTL + OFF_CMD))
            rd_data[NCH-1:0] = tc_flag_q;
        dout_d = rd_en ? rd_data : dout_q;
    end

    // Shared registers; terminal-count effects are applied last so they win.
    always_comb begin
        cmd_d     = cmd_q;
        req_d     = req_q;
        mask_d    = mask_q;
        mode_d    = mode_q;
        tc_flag_d = tc_flag_q;
        if (wr_cmd)
            cmd_d = din;
        for (int c = 0; c < NCH; c++) begin
            if (wr_req && sel == 32'(c))
                req_d[c] = din[CHW];
            if (wr_smask && sel == 32'(c))
                mask_d[c] = din[CHW];
            if (reg_wr && addr_i == 32'(CTL + OFF_MODE + c))
                mode_d[c*MODE_W +: MODE_W] = din[MODE_W-1:0];
        end
        if (wr_clrmask)
            mask_d = '0;
        if (wr_wrmask)
            mask_d = din[NCH-1:0];
        if (rd_stat)
            tc_flag_d = '0;
        if (wr_mclr) begin
            cmd_d     = '0;
            req_d     = '0;
            mask_d    = '1;
            tc_flag_d = '0;
        end
        tc_flag_d = tc_flag_d | tc_c;
        for (int c = 0; c < NCH; c++) begin
            if (tc_c[c]) begin
                req_d[c] = 1'b0;
                if (!autoinit_c[c])
                    mask_d[c] = 1'b1;
            end
        end
        tc_pulse_d = tc_c;
    end

    // Register state; masks come out of reset set.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptr_q      <= '0;
            tc_flag_q  <= '0;
            tc_pulse_q <= '0;
            dout_q     <= '0;
            cmd_q      <= '0;
            req_q      <= '0;
            mask_q     <= '1;
            mode_q     <= '0;
        end else begin
            ptr_q      <= ptr_d;
            tc_flag_q  <= tc_flag_d;
            tc_pulse_q <= tc_pulse_d;
            dout_q     <= dout_d;
            cmd_q      <= cmd_d;
            req_q      <= req_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
        end
    end

endmodule

// File: tb/tb_dma_chan_regfile.sv
// Directed bench for dma_chan_regfile (NCH=4, DW=8, AW=16). Stimulus pushes
// expected values into a scoreboard queue; a negedge monitor pops them when
// a read result is due or when a state snapshot is requested.
module tb_dma_chan_regfile;

    localparam int NCH = 4;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int RAW = 5;
    localparam int CHW = 2;

    localparam int K_CADDR = 1, K_CWORD = 2, K_MASK = 3, K_REQ = 4;
    localparam int K_CMD = 5, K_MODE = 6, K_TCP = 7, K_DOUT = 8;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              reg_wr = 1'b0, reg_rd = 1'b0;
    logic [RAW-1:0]    reg_addr = '0;
    logic [DW-1:0]     din = '0;
    logic [DW-1:0]     dout;
    logic              xfer_step = 1'b0;
    logic [CHW-1:0]    xfer_ch = '0;
    logic [NCH-1:0]    tc_pulse;
    logic [NCH*AW-1:0] curr_addr, curr_word;
    logic [NCH*6-1:0]  mode_q;
    logic [DW-1:0]     cmd_q;
    logic [NCH-1:0]    req_q, mask_q;

    dma_chan_regfile #(.NCH(NCH), .DW(DW), .AW(AW)) dut (
        .CLK(CLK), .RESET(RESET), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .reg_addr(reg_addr), .din(din), .dout(dout), .xfer_step(xfer_step),
        .xfer_ch(xfer_ch), .tc_pulse(tc_pulse), .curr_addr(curr_addr),
        .curr_word(curr_word), .mode_q(mode_q), .cmd_q(cmd_q),
        .req_q(req_q), .mask_q(mask_q)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       nm;
        int          sig;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;
    logic snap = 1'b0;
    logic rd_pend = 1'b0;

    function automatic logic [31:0] sig_val(input int s);
        int c;
        c = s % 16;
        case (s / 16)
            K_CADDR: return 32'(curr_addr[c*AW +: AW]);
            K_CWORD: return 32'(curr_word[c*AW +: AW]);
            K_MASK:  return 32'(mask_q);
            K_REQ:   return 32'(req_q);
            K_CMD:   return 32'(cmd_q);
            K_MODE:  return 32'(mode_q[c*6 +: 6]);
            K_TCP:   return 32'(tc_pulse);
            K_DOUT:  return 32'(dout);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exv);
        n_cmp++;
        if (act !== exv) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exv);
        end
    endtask

    // A read launched at this edge has its data on dout for the next negedge.
    always @(posedge CLK) rd_pend <= reg_rd & ~reg_wr;

    // Monitor: pop read results and snapshot expectations.
    always @(negedge CLK) begin
        if (rd_pend) begin
            if (sb.size() == 0 || sb[0].sig != 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_read: got %0h expected no read", dout);
            end else begin
                e = sb.pop_front();
                cmp(e.nm, 32'(dout), e.val);
            end
        end
        if (snap) begin
            while (sb.size() > 0 && sb[0].sig != 0) begin
                e = sb.pop_front();
                cmp(e.nm, sig_val(e.sig), e.val);
            end
        end
    end

    task automatic idle_in();
        reg_wr = 1'b0; reg_rd = 1'b0; xfer_step = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        reg_wr = 1'b1; reg_addr = RAW'(a); din = DW'(d);
        @(posedge CLK); #1; idle_in();
    endtask

    task automatic rd(input int a, input int exv, input string nm);
        sb.push_back('{nm, 0, 32'(exv)});
        reg_rd = 1'b1; reg_addr = RAW'(a);
        @(posedge CLK); #1; idle_in();
    endtask

    task automatic step(input int ch);
        xfer_step = 1'b1; xfer_ch = CHW'(ch);
        @(posedge CLK); #1; idle_in();
    endtask

    task automatic wr_step(input int a, input int d, input int ch);
        reg_wr = 1'b1; reg_addr = RAW'(a); din = DW'(d);
        xfer_step = 1'b1; xfer_ch = CHW'(ch);
        @(posedge CLK); #1; idle_in();
    endtask

    task automatic rd_step(input int a, input int exv, input string nm, input int ch);
        sb.push_back('{nm, 0, 32'(exv)});
        reg_rd = 1'b1; reg_addr = RAW'(a);
        xfer_step = 1'b1; xfer_ch = CHW'(ch);
        @(posedge CLK); #1; idle_in();
    endtask

    task automatic wr_rd(input int a, input int d);
        reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = RAW'(a); din = DW'(d);
        @(posedge CLK); #1; idle_in();
    endtask

    task automatic exp_chk(input int kind, input int c, input int v, input string nm);
        sb.push_back('{nm, kind * 16 + c, 32'(v)});
    endtask

    task automatic snap_t();
        snap = 1'b1;
        @(negedge CLK); #1;
        snap = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1 RESET = 1'b1;

        // Reset values
        exp_chk(K_MASK, 0, 'hF, "rst_mask");
        exp_chk(K_REQ, 0, 0, "rst_req");
        exp_chk(K_CMD, 0, 0, "rst_cmd");
        exp_chk(K_TCP, 0, 0, "rst_tcp");
        exp_chk(K_DOUT, 0, 0, "rst_dout");
        exp_chk(K_CWORD, 3, 0, "rst_cword3");
        snap_t();

        // Byte write through the shared pointer
        wr(12, 0);
        wr(2, 'h34);
        wr(2, 'h12);
        exp_chk(K_CADDR, 1, 'h1234, "bytewr_caddr1");
        snap_t();
        rd(2, 'h34, "bytewr_rd_lo");
        rd(2, 'h12, "bytewr_rd_hi");

        // Terminal count without autoinit on ch0
        wr(16, 'h00);
        wr(1, 'h01);
        wr(1, 'h00);
        wr(14, 0);
        wr(9, 'h04);
        exp_chk(K_REQ, 0, 'h1, "req_set");
        exp_chk(K_MASK, 0, 'h0, "mask_clrall");
        snap_t();
        step(0);
        exp_chk(K_CWORD, 0, 'h0000, "tc_step1_word");
        exp_chk(K_CADDR, 0, 'h0001, "tc_step1_addr");
        exp_chk(K_TCP, 0, 0, "tc_step1_nopulse");
        snap_t();
        step(0);
        exp_chk(K_CWORD, 0, 'hFFFF, "tc_word_wrap");
        exp_chk(K_CADDR, 0, 'h0002, "tc_addr");
        exp_chk(K_TCP, 0, 'h1, "tc_pulse");
        exp_chk(K_MASK, 0, 'h1, "tc_automask");
        exp_chk(K_REQ, 0, 'h0, "tc_req_clr");
        snap_t();
        exp_chk(K_TCP, 0, 'h0, "tc_pulse_gone");
        snap_t();
        rd(8, 'h01, "status_tc0");
        rd(8, 'h00, "status_cleared");

        // Autoinit on ch2
        wr(18, 'h04);
        wr(4, 'h00);
        wr(4, 'h10);
        wr(5, 'h02);
        wr(5, 'h00);
        step(2);
        step(2);
        exp_chk(K_CADDR, 2, 'h1002, "ai_addr2");
        exp_chk(K_CWORD, 2, 'h0000, "ai_word2");
        snap_t();
        step(2);
        exp_chk(K_CADDR, 2, 'h1000, "ai_reload_addr");
        exp_chk(K_CWORD, 2, 'h0002, "ai_reload_word");
        exp_chk(K_TCP, 0, 'h4, "ai_pulse");
        exp_chk(K_MASK, 0, 'h1, "ai_mask_kept");
        snap_t();

        // Address decrement on ch3
        wr(19, 'h08);
        wr(7, 'h05);
        wr(7, 'h00);
        step(3);
        exp_chk(K_CADDR, 3, 'hFFFF, "dec_addr");
        exp_chk(K_CWORD, 3, 'h0004, "dec_word");
        exp_chk(K_MODE, 3, 'h08, "dec_mode");
        snap_t();

        // Word write on ch1 collides with a step on ch1: step dropped
        wr_step(3, 'h07, 1);
        exp_chk(K_TCP, 0, 'h0, "coll_no_tc");
        exp_chk(K_CADDR, 1, 'h1234, "coll_addr_kept");
        snap_t();
        wr(3, 'h00);
        exp_chk(K_CWORD, 1, 'h0007, "coll_word");
        snap_t();

        // Status read in the same cycle as a new terminal count on ch0
        wr(1, 0);
        wr(1, 0);
        rd_step(8, 'h04, "stat_coll_old", 0);
        exp_chk(K_TCP, 0, 'h1, "stat_coll_pulse");
        exp_chk(K_CWORD, 0, 'hFFFF, "stat_coll_word");
        exp_chk(K_CADDR, 0, 'h0003, "stat_coll_addr");
        snap_t();
        rd(8, 'h01, "stat_coll_kept");
        rd(8, 'h00, "stat_coll_clr");

        // Single mask clear loses to auto-mask in the same cycle
        wr(10, 'h00);
        exp_chk(K_MASK, 0, 'h0, "smask_clr");
        snap_t();
        wr(1, 0);
        wr(1, 0);
        wr_step(10, 'h00, 0);
        exp_chk(K_MASK, 0, 'h1, "smask_vs_tc");
        exp_chk(K_TCP, 0, 'h1, "smask_tc_pulse");
        exp_chk(K_CADDR, 0, 'h0004, "smask_addr");
        snap_t();
        rd(8, 'h01, "smask_status");
        wr(10, 'h06);
        exp_chk(K_MASK, 0, 'h5, "smask_set2");
        snap_t();
        wr(15, 'h0A);
        exp_chk(K_MASK, 0, 'hA, "mask_wrall");
        snap_t();

        // Command disable freezes steps
        wr(8, 'h04);
        step(3);
        exp_chk(K_CMD, 0, 'h04, "cmd_wr");
        exp_chk(K_CADDR, 3, 'hFFFF, "dis_addr");
        exp_chk(K_CWORD, 3, 'h0004, "dis_word");
        snap_t();

        // Master clear after programming; pointer left at lane 1 first
        wr(9, 'h05);
        exp_chk(K_REQ, 0, 'h2, "req_ch1");
        snap_t();
        wr(6, 'hAA);
        wr(13, 0);
        exp_chk(K_MASK, 0, 'hF, "mclr_mask");
        exp_chk(K_CMD, 0, 'h0, "mclr_cmd");
        exp_chk(K_REQ, 0, 'h0, "mclr_req");
        exp_chk(K_MODE, 2, 'h04, "mclr_mode2");
        exp_chk(K_CADDR, 1, 'h1234, "mclr_caddr1");
        exp_chk(K_CADDR, 3, 'hFFAA, "mclr_caddr3");
        snap_t();
        rd(6, 'hAA, "mclr_ptr_lo");
        rd(6, 'hFF, "mclr_ptr_hi");
        wr_rd(15, 'h03);
        exp_chk(K_MASK, 0, 'h3, "wrrd_mask");
        exp_chk(K_DOUT, 0, 'hFF, "wrrd_dout_held");
        snap_t();
        rd(11, 'h00, "unmapped_11");
        rd(25, 'h00, "unmapped_25");

        // Reset asserted mid-step with the pointer at lane 1
        wr(0, 'h11);
        xfer_step = 1'b1; xfer_ch = 2'd3;
        #2 RESET = 1'b0;
        exp_chk(K_MASK, 0, 'hF, "arst_mask");
        exp_chk(K_CADDR, 3, 'h0000, "arst_caddr3");
        exp_chk(K_CWORD, 3, 'h0000, "arst_cword3");
        exp_chk(K_MODE, 3, 'h00, "arst_mode3");
        exp_chk(K_TCP, 0, 'h0, "arst_tcp");
        exp_chk(K_DOUT, 0, 'h00, "arst_dout");
        snap_t();
        idle_in();
        RESET = 1'b1;
        wr(0, 'hCD);
        exp_chk(K_CADDR, 0, 'h00CD, "arst_ptr_lane0");
        snap_t();

        repeat (2) @(posedge CLK);
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL leftover: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
